// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - two-stage FP32 multiply back end: normalize, round to nearest even, pack
// Stage 1 normalizes the 48-bit product. Stage 2 rounds it and resolves overflow, underflow and special operands.
module fp_mul_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [47:0] in_man,
  input  logic        in_zero,
  input  logic        in_inf,
  input  logic        in_nan,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic               s1_valid, s1_sign, s1_guard, s1_sticky, s1_zero, s1_inf, s1_nan;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_kept;

  logic [23:0]        n_kept;
  logic               n_guard, n_sticky;
  logic signed [9:0]  n_exp;

  always_comb begin
    n_kept   = in_man[46:23];
    n_guard  = in_man[22];
    n_sticky = |in_man[21:0];
    if (in_man[47]) begin
      n_kept   = in_man[47:24];
      n_guard  = in_man[23];
      n_sticky = |in_man[22:0];
    end
    n_exp = $signed({1'b0, in_exp}) - 10'sd127 + $signed({9'd0, in_man[47]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_kept   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_exp    <= n_exp;
      s1_kept   <= n_kept;
      s1_guard  <= n_guard;
      s1_sticky <= n_sticky;
      s1_zero   <= in_zero;
      s1_inf    <= in_inf;
      s1_nan    <= in_nan;
    end
  end

  // A round-up carry only escapes when kept is all ones; the 23-bit fraction then wraps to zero.
  logic               round_up, carry;
  logic [22:0]        r_frac;
  logic signed [9:0]  r_exp;
  logic [31:0]        n_result;
  logic               n_ovf, n_unf, n_inexact;

  always_comb begin
    round_up  = s1_guard && (s1_sticky || s1_kept[0]);
    carry     = round_up && (&s1_kept);
    r_frac    = s1_kept[22:0] + {22'd0, round_up};
    r_exp     = s1_exp + $signed({9'd0, carry});
    n_result  = {s1_sign, r_exp[7:0], r_frac};
    n_ovf     = 1'b0;
    n_unf     = 1'b0;
    n_inexact = s1_guard || s1_sticky;
    if (r_exp >= 10'sd255) begin
      n_result  = {s1_sign, 8'hFF, 23'd0};
      n_ovf     = 1'b1;
      n_inexact = 1'b1;
    end else if (r_exp <= 10'sd0) begin
      n_result  = {s1_sign, 31'd0};
      n_unf     = 1'b1;
      n_inexact = 1'b1;
    end
    if (s1_nan || s1_inf || s1_zero) begin
      n_ovf     = 1'b0;
      n_unf     = 1'b0;
      n_inexact = 1'b0;
      if (s1_nan)      n_result = 32'h7FC00000;
      else if (s1_inf) n_result = {s1_sign, 8'hFF, 23'd0};
      else             n_result = {s1_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv) begin
      out_valid   <= s1_valid;
      out_result  <= n_result;
      out_ovf     <= n_ovf;
      out_unf     <= n_unf;
      out_inexact <= n_inexact;
    end
  end

endmodule
